// File: rtl/enc_pulse_gen.sv
// Encoder emulator: programmable A pulse train with a Z index pulse every N A pulses.
// It supports finite bursts and continuous runs, and counts the A rising edges emitted since start.
module enc_pulse_gen #(
    parameter int P_TIME_WIDTH  = 32,
    parameter int P_ZNUM_WIDTH  = 16,
    parameter int P_BURST_WIDTH = 32
) (
    input  logic                     CLK,
    input  logic                     ResetN,
    input  logic                     I_START,
    input  logic                     I_STOP,
    input  logic [P_TIME_WIDTH-1:0]  I_PERIOD,
    input  logic [P_TIME_WIDTH-1:0]  I_HIGH,
    input  logic [P_ZNUM_WIDTH-1:0]  I_Z_NUM,
    input  logic [P_BURST_WIDTH-1:0] I_BURST,
    output logic                     O_A,
    output logic                     O_Z,
    output logic                     O_ARM,
    output logic                     O_BUSY,
    output logic                     O_DONE,
    output logic [63:0]              O_PULSE_CNT
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HIGH = 2'd1;
    localparam logic [1:0] S_LOW  = 2'd2;

    localparam logic [P_TIME_WIDTH-1:0] T_ONE = {{(P_TIME_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [P_ZNUM_WIDTH-1:0] Z_ONE = {{(P_ZNUM_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]               state;
    logic                     rise_pend;
    logic                     z_pend;
    logic [P_TIME_WIDTH-1:0]  high_len;
    logic [P_TIME_WIDTH-1:0]  low_len;
    logic [P_TIME_WIDTH-1:0]  ph;
    logic [P_ZNUM_WIDTH-1:0]  z_num;
    logic [P_ZNUM_WIDTH-1:0]  zcnt;
    logic [P_BURST_WIDTH-1:0] burst;

    logic [P_TIME_WIDTH-1:0]  h_legal;
    logic [P_TIME_WIDTH-1:0]  low_legal;
    logic [P_ZNUM_WIDTH-1:0]  zcnt_next;
    logic                     z_hit;
    logic                     burst_hit;
    logic                     low_end;
    logic                     do_rise;

    // Low length is stored instead of the period so H+1 can never overflow.
    always_comb begin
        h_legal   = (I_HIGH == '0) ? T_ONE : I_HIGH;
        low_legal = (I_PERIOD > h_legal) ? (I_PERIOD - h_legal) : T_ONE;
        zcnt_next = zcnt + Z_ONE;
        z_hit     = (z_num != '0) && (zcnt_next == z_num);
        burst_hit = (burst != '0) && (O_PULSE_CNT == {{(64-P_BURST_WIDTH){1'b0}}, burst});
        low_end   = (state == S_LOW) && (ph == low_len);
        do_rise   = !I_STOP && (((state == S_HIGH) && rise_pend) || (low_end && !burst_hit));
    end

    always_ff @(posedge CLK or negedge ResetN) begin
        if (!ResetN) begin
            state       <= S_IDLE;
            rise_pend   <= 1'b0;
            z_pend      <= 1'b0;
            high_len    <= '0;
            low_len     <= '0;
            ph          <= '0;
            z_num       <= '0;
            zcnt        <= '0;
            burst       <= '0;
            O_A         <= 1'b0;
            O_Z         <= 1'b0;
            O_ARM       <= 1'b0;
            O_BUSY      <= 1'b0;
            O_DONE      <= 1'b0;
            O_PULSE_CNT <= '0;
        end else begin
            O_DONE <= 1'b0;
            O_Z    <= z_pend;
            z_pend <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (I_START && !I_STOP) begin
                        state       <= S_HIGH;
                        rise_pend   <= 1'b1;
                        high_len    <= h_legal;
                        low_len     <= low_legal;
                        z_num       <= I_Z_NUM;
                        burst       <= I_BURST;
                        ph          <= '0;
                        zcnt        <= '0;
                        O_PULSE_CNT <= '0;
                    end
                end
                S_HIGH: begin
                    if (!I_STOP && !rise_pend) begin
                        if (ph == high_len) begin
                            state <= S_LOW;
                            O_A   <= 1'b0;
                            ph    <= T_ONE;
                        end else begin
                            ph <= ph + T_ONE;
                        end
                    end
                end
                S_LOW: begin
                    if (!I_STOP) begin
                        if (low_end && burst_hit) begin
                            state  <= S_IDLE;
                            O_ARM  <= 1'b0;
                            O_BUSY <= 1'b0;
                            O_DONE <= 1'b1;
                        end else if (!low_end) begin
                            ph <= ph + T_ONE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase

            // Shared A-rise update: first pulse after start and every LOW->HIGH wrap.
            if (do_rise) begin
                state       <= S_HIGH;
                rise_pend   <= 1'b0;
                ph          <= T_ONE;
                O_A         <= 1'b1;
                O_ARM       <= 1'b1;
                O_BUSY      <= 1'b1;
                O_PULSE_CNT <= O_PULSE_CNT + 64'd1;
                z_pend      <= z_hit;
                zcnt        <= z_hit ? '0 : zcnt_next;
            end

            // Abort from any active state; the pulse count is deliberately kept.
            if (I_STOP && (state != S_IDLE)) begin
                state     <= S_IDLE;
                rise_pend <= 1'b0;
                z_pend    <= 1'b0;
                O_A       <= 1'b0;
                O_Z       <= 1'b0;
                O_ARM     <= 1'b0;
                O_BUSY    <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_enc_pulse_gen.sv
// Bench for enc_pulse_gen: per-cycle waveform compared against an arithmetic timing model.
module tb_enc_pulse_gen;
    logic        CLK;
    logic        ResetN;
    logic        I_START;
    logic        I_STOP;
    logic [31:0] I_PERIOD;
    logic [31:0] I_HIGH;
    logic [15:0] I_Z_NUM;
    logic [31:0] I_BURST;
    logic        O_A;
    logic        O_Z;
    logic        O_ARM;
    logic        O_BUSY;
    logic        O_DONE;
    logic [63:0] O_PULSE_CNT;

    int checks = 0;
    int failures = 0;
    logic [68:0] exp_q[$];
    logic [63:0] model_cnt = 64'd0;

    enc_pulse_gen #(.P_TIME_WIDTH(32), .P_ZNUM_WIDTH(16), .P_BURST_WIDTH(32)) dut (
        .CLK(CLK), .ResetN(ResetN), .I_START(I_START), .I_STOP(I_STOP),
        .I_PERIOD(I_PERIOD), .I_HIGH(I_HIGH), .I_Z_NUM(I_Z_NUM), .I_BURST(I_BURST),
        .O_A(O_A), .O_Z(O_Z), .O_ARM(O_ARM), .O_BUSY(O_BUSY), .O_DONE(O_DONE),
        .O_PULSE_CNT(O_PULSE_CNT)
    );

    // clock / reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Vector layout: {done, busy, arm, z, a, pulse_cnt}
    function automatic logic [68:0] obs();
        return {O_DONE, O_BUSY, O_ARM, O_Z, O_A, O_PULSE_CNT};
    endfunction

    task automatic check_eq(input string tag, input logic [68:0] got, input logic [68:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected outputs t cycles after the start edge, from the legalised H/P and the burst rules.
    function automatic logic [68:0] model(input int t, input int h, input int p, input int z, input int b);
        int n;
        int w;
        logic a;
        logic zo;
        if (t == 0) return 69'd0;
        if (b != 0 && t > b * p)
            return {(t == b * p + 1), 4'b0000, 64'(b)};
        n  = (t - 1) / p;
        w  = (t - 1) % p;
        a  = (w < h);
        zo = (z != 0) && (w == 1) && (((n + 1) % z) == 0);
        return {1'b0, 1'b1, 1'b1, zo, a, 64'(n + 1)};
    endfunction

    // Caller is at a negedge. stop_at: edge index (after start edge) at which I_STOP is sampled, 0 = none.
    task automatic run(input int hi, input int per, input int zn, input int b,
                       input int stop_at, input int tail);
        int h;
        int p;
        int tmax;
        logic [63:0] held;
        h = (hi == 0) ? 1 : hi;
        p = (per > h) ? per : h + 1;
        I_PERIOD = 32'(per);
        I_HIGH   = 32'(hi);
        I_Z_NUM  = 16'(zn);
        I_BURST  = 32'(b);
        I_START  = 1'b1;
        I_STOP   = 1'b0;
        @(negedge CLK);
        I_START = 1'b0;
        check_eq("start_pend", obs(), model(0, h, p, zn, b));
        tmax = (stop_at != 0) ? stop_at - 1 : b * p + tail;
        for (int t = 1; t <= tmax; t++) exp_q.push_back(model(t, h, p, zn, b));
        for (int t = 1; t <= tmax; t++) begin
            I_PERIOD = $urandom_range(0, 20);
            I_HIGH   = $urandom_range(0, 20);
            I_Z_NUM  = 16'($urandom_range(0, 5));
            I_BURST  = $urandom_range(0, 9);
            I_START  = (b == 0 || t <= b * p) ? ($urandom_range(0, 7) == 0) : 1'b0;
            @(negedge CLK);
            check_eq($sformatf("run h=%0d p=%0d z=%0d b=%0d t=%0d", h, p, zn, b, t),
                     obs(), exp_q.pop_front());
        end
        I_START = 1'b0;
        if (stop_at != 0) begin
            held = model(stop_at - 1, h, p, zn, b);
            I_STOP  = 1'b1;
            I_START = 1'($urandom_range(0, 1));
            @(negedge CLK);
            I_STOP  = 1'b0;
            I_START = 1'b0;
            check_eq("stop", obs(), {5'b0, held});
            @(negedge CLK);
            check_eq("stop_hold", obs(), {5'b0, held});
            model_cnt = held;
        end else begin
            model_cnt = 64'(b);
        end
    endtask

    initial begin
        ResetN   = 1'b0;
        I_START  = 1'b0;
        I_STOP   = 1'b0;
        I_PERIOD = '0;
        I_HIGH   = '0;
        I_Z_NUM  = '0;
        I_BURST  = '0;
        repeat (2) @(negedge CLK);
        check_eq("reset_state", obs(), 69'd0);
        ResetN = 1'b1;
        @(negedge CLK);
        check_eq("idle_after_reset", obs(), 69'd0);

        // basic burst: P=10 H=3 Z=3 B=7
        run(3, 10, 3, 7, 0, 3);
        check_eq("burst7_cnt", {5'b0, O_PULSE_CNT}, 69'd7);

        // legalisation, then a start in the cycle right after O_DONE
        run(0, 0, 2, 4, 0, 1);
        run(1, 3, 1, 3, 0, 2);

        // continuous run stopped after 50 cycles
        run(2, 4, 0, 0, 51, 0);
        check_eq("cont_cnt13", {5'b0, O_PULSE_CNT}, 69'd13);

        // start and stop together in IDLE: stop wins
        I_START = 1'b1;
        I_STOP  = 1'b1;
        I_PERIOD = 32'd5;
        @(negedge CLK);
        I_START = 1'b0;
        I_STOP  = 1'b0;
        check_eq("collide", obs(), {5'b0, model_cnt});
        @(negedge CLK);
        check_eq("collide_hold", obs(), {5'b0, model_cnt});
        // stop in IDLE does nothing
        I_STOP = 1'b1;
        @(negedge CLK);
        I_STOP = 1'b0;
        check_eq("idle_stop", obs(), {5'b0, model_cnt});

        // randomized runs
        for (int r = 0; r < 10; r++) begin
            int hi;
            int per;
            int zn;
            int b;
            int hh;
            int pp;
            int st;
            hi  = $urandom_range(0, 5);
            per = $urandom_range(0, 12);
            zn  = $urandom_range(0, 4);
            b   = $urandom_range(0, 6);
            hh  = (hi == 0) ? 1 : hi;
            pp  = (per > hh) ? per : hh + 1;
            if (b == 0) st = $urandom_range(1, 40);
            else if ($urandom_range(0, 1) == 1) st = $urandom_range(1, b * pp);
            else st = 0;
            run(hi, per, zn, b, st, $urandom_range(1, 3));
        end

        // asynchronous reset in the middle of a HIGH phase
        run(3, 10, 0, 0, 0, 0);
        repeat (2) @(negedge CLK);
        #1 ResetN = 1'b0;
        #1 check_eq("reset_async", obs(), 69'd0);
        @(negedge CLK);
        ResetN = 1'b1;
        @(negedge CLK);
        check_eq("reset_release_idle", obs(), 69'd0);

        // long burst, as a loopback counter cross-check
        run(1, 2, 5, 250, 0, 2);
        check_eq("burst250_cnt", {5'b0, O_PULSE_CNT}, 69'd250);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
